// File: rtl/seq_calc_pkg.sv
// rtl/seq_calc_pkg.sv - function codes, FSM states and CMP bit positions for seq_calc_unit
package seq_calc_pkg;

  localparam logic [2:0] FCT_ADD = 3'b000;
  localparam logic [2:0] FCT_SUB = 3'b001;
  localparam logic [2:0] FCT_MUL = 3'b010;
  localparam logic [2:0] FCT_CMP = 3'b011;
  localparam logic [2:0] FCT_DIV = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int CMP_LT = 0;
  localparam int CMP_EQ = 1;
  localparam int CMP_GT = 2;

endpackage

// File: rtl/seq_calc_iter.sv
// rtl/seq_calc_iter.sv - shared shift/accumulate datapath for shift-add MUL and restoring DIV
module seq_calc_iter
  import seq_calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               op_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] res_next_o
);

  // MUL: acc = {partial product, remaining multiplier bits}, opr = multiplicand
  // DIV: acc = {partial remainder, dividend bits becoming quotient}, opr = divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opr_q, opr_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;

  // one load or one bit step; the next value is exposed so the final step can be captured directly
  always_comb begin
    acc_d    = acc_q;
    opr_d    = opr_q;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opr_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, opr_q};
    if (load_i) begin
      acc_d = {{WIDTH{1'b0}}, (op_div_i ? a_i : b_i)};
      opr_d = op_div_i ? b_i : a_i;
    end else if (step_i) begin
      if (op_div_i) begin
        if (!div_diff[WIDTH]) begin
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
    end
    res_next_o = acc_d;
  end

  // datapath registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      acc_q <= '0;
      opr_q <= '0;
    end else begin
      acc_q <= acc_d;
      opr_q <= opr_d;
    end
  end

endmodule

// File: rtl/seq_calc_unit.sv
// rtl/seq_calc_unit.sv - multi-cycle arithmetic unit top; optional signed MUL/CMP via SEQ_CALC_SIGNED_EN
module seq_calc_unit
  import seq_calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2:0]         fct_i,
`ifdef SEQ_CALC_SIGNED_EN
  input  logic               signed_i,
`endif
  output logic [2*WIDTH-1:0] s_o,
  output logic               flag_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] s_q, s_d;
  logic               flag_q, flag_d;
  logic               done_q, done_d;
  logic               op_div_q, op_div_d;

  logic               iter_load, iter_step, iter_div;
  logic [WIDTH-1:0]   iter_a, iter_b;
  logic [2*WIDTH-1:0] iter_res;
  logic [2*WIDTH-1:0] prod;
  logic               mul_flag;
  logic [WIDTH:0]     add_sum;
  logic               cmp_lt, cmp_eq, cmp_gt;

`ifdef SEQ_CALC_SIGNED_EN
  logic               sgn_q, sgn_d;
  logic               neg_q, neg_d;
`endif

  seq_calc_iter #(.WIDTH(WIDTH)) u_iter (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (iter_load),
    .step_i     (iter_step),
    .op_div_i   (iter_div),
    .a_i        (iter_a),
    .b_i        (iter_b),
    .res_next_o (iter_res)
  );

  // operand preparation: single-cycle results, MUL magnitudes and product sign fix-up
  always_comb begin
    add_sum = {1'b0, a_i} + {1'b0, b_i};
    cmp_eq  = (a_i == b_i);
    cmp_lt  = (a_i < b_i);
    iter_a  = a_i;
    iter_b  = b_i;
    prod    = iter_res;
`ifdef SEQ_CALC_SIGNED_EN
    if (signed_i) begin
      cmp_lt = ($signed(a_i) < $signed(b_i));
    end
    if (signed_i && (fct_i == FCT_MUL)) begin
      if (a_i[WIDTH-1]) iter_a = -a_i;
      if (b_i[WIDTH-1]) iter_b = -b_i;
    end
    if (neg_q) begin
      prod = -iter_res;
    end
`endif
    cmp_gt   = !cmp_lt && !cmp_eq;
    mul_flag = |prod[2*WIDTH-1:WIDTH];
`ifdef SEQ_CALC_SIGNED_EN
    if (sgn_q) begin
      mul_flag = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
    end
`endif
  end

  // control FSM: accept in IDLE, finish single-cycle ops at once, count WIDTH steps in RUN
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    flag_d    = flag_q;
    done_d    = 1'b0;
    op_div_d  = op_div_q;
    iter_load = 1'b0;
    iter_step = 1'b0;
    iter_div  = (state_q == ST_IDLE) ? (fct_i == FCT_DIV) : op_div_q;
`ifdef SEQ_CALC_SIGNED_EN
    sgn_d     = sgn_q;
    neg_d     = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          done_d = 1'b1;
          case (fct_i)
            FCT_ADD: begin
              s_d    = {{(WIDTH-1){1'b0}}, add_sum};
              flag_d = add_sum[WIDTH];
            end
            FCT_SUB: begin
              s_d    = {{WIDTH{1'b0}}, a_i - b_i};
              flag_d = (a_i < b_i);
            end
            FCT_CMP: begin
              s_d         = '0;
              s_d[CMP_LT] = cmp_lt;
              s_d[CMP_EQ] = cmp_eq;
              s_d[CMP_GT] = cmp_gt;
              flag_d      = cmp_eq;
            end
            FCT_MUL, FCT_DIV: begin
              if ((fct_i == FCT_DIV) && (b_i == '0)) begin
                s_d    = '1;
                flag_d = 1'b1;
              end else begin
                done_d    = 1'b0;
                iter_load = 1'b1;
                op_div_d  = (fct_i == FCT_DIV);
                cnt_d     = CNT_W'(WIDTH);
                state_d   = ST_RUN;
`ifdef SEQ_CALC_SIGNED_EN
                sgn_d     = signed_i && (fct_i == FCT_MUL);
                neg_d     = signed_i && (fct_i == FCT_MUL) && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`endif
              end
            end
            default: begin
              s_d    = '0;
              flag_d = 1'b1;
            end
          endcase
        end
      end
      ST_RUN: begin
        iter_step = 1'b1;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          s_d     = op_div_q ? iter_res : prod;
          flag_d  = op_div_q ? 1'b0 : mul_flag;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      s_q      <= '0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
      op_div_q <= 1'b0;
`ifdef SEQ_CALC_SIGNED_EN
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      flag_q   <= flag_d;
      done_q   <= done_d;
      op_div_q <= op_div_d;
`ifdef SEQ_CALC_SIGNED_EN
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
`endif
    end
  end

  assign s_o    = s_q;
  assign flag_o = flag_q;
  assign busy_o = (state_q == ST_RUN);
  assign done_o = done_q;

endmodule
